// File: rtl/sdp_fifo_pkg.sv
// rtl/sdp_fifo_pkg.sv - shared defaults, depth helper and buffer-occupancy type for sdp_fifo_ctrl
package sdp_fifo_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 16;

  typedef logic [1:0] occ_t;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sdp_fifo_obuf.sv
// rtl/sdp_fifo_obuf.sv - 2-entry first-word-fall-through output buffer with in-flight read tracking
module sdp_fifo_obuf
  import sdp_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_issue,
  input  logic [DATA_W-1:0] ram_dob,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output occ_t              occ,
  output logic              inflight,
  output logic              room
);

  logic              pop;
  occ_t              tail_idx;
  logic [DATA_W-1:0] ent0;
  logic [DATA_W-1:0] ent1;

  assign rd_valid = (occ != 2'd0);
  assign rd_data  = ent0;
  assign pop      = rd_valid & rd_ready;
  assign tail_idx = occ - {1'b0, pop};
  // Room for another read once this cycle's pop has freed its slot.
  assign room     = (({1'b0, occ} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      occ      <= occ - {1'b0, pop} + {1'b0, inflight};
      inflight <= rd_issue;
    end
  end

  // The returning word lands behind whatever survives this cycle's pop.
  always_ff @(posedge clk) begin
    if (pop) ent0 <= ent1;
    if (inflight) begin
      if (tail_idx == 2'd0) ent0 <= ram_dob;
      else                  ent1 <= ram_dob;
    end
  end

endmodule

// File: rtl/sdp_fifo_ctrl.sv
// rtl/sdp_fifo_ctrl.sv - simple-dual-port RAM FIFO controller; SDP_FIFO_ALMOST_EN adds almost_full/almost_empty
module sdp_fifo_ctrl
  import sdp_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef SDP_FIFO_ALMOST_EN
  ,
  parameter int AF_LVL = depth(ADDR_W) - 4,
  parameter int AE_LVL = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W+1:0] count,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dia,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_dob
`ifdef SDP_FIFO_ALMOST_EN
  ,
  output logic              almost_full,
  output logic              almost_empty
`endif
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              push;
  logic              rd_issue;
  logic              room;
  logic              inflight;
  occ_t              occ;

  assign wr_ready  = (ram_cnt != FULL_CNT);
  assign push      = wr_valid & wr_ready & rst_n;
  assign rd_issue  = (ram_cnt != '0) & room;

  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wptr;
  assign ram_dia   = wr_data;
  assign ram_enb   = rd_issue;
  assign ram_addrb = rptr;

  assign count = {1'b0, ram_cnt} + {{ADDR_W{1'b0}}, occ} + {{(ADDR_W+1){1'b0}}, inflight};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
    end else begin
      if (push)     wptr <= wptr + PTR_ONE;
      if (rd_issue) rptr <= rptr + PTR_ONE;
      case ({push, rd_issue})
        2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
        2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  sdp_fifo_obuf #(
    .DATA_W(DATA_W)
  ) u_obuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_issue(rd_issue),
    .ram_dob (ram_dob),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .occ     (occ),
    .inflight(inflight),
    .room    (room)
  );

`ifdef SDP_FIFO_ALMOST_EN
  localparam logic [ADDR_W+1:0] AF_C = AF_LVL[ADDR_W+1:0];
  localparam logic [ADDR_W+1:0] AE_C = AE_LVL[ADDR_W+1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count >= AF_C);
      almost_empty <= (count <= AE_C);
    end
  end
`endif

endmodule
